alu_result_acc: RTL and testbench

ALU_RESULT_ACC -- requirements
Module: alu_result_acc

---
 rtl/alu_result_acc.sv | 76 +++++++
 tb/tb_alu_result_acc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_acc.sv
// alu_result_acc: windowed, saturating accumulator of signed 5-bit ALU results with a valid/ready output handshake
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   in_valid  : c_in carries a result this cycle
//   in_ready  : high while accumulating (state ACCUM)
//   c_in      : signed ALU result, -16..15
//   flush     : close the current window early (ignored if the window is empty)
//   out_valid : high while a closed window is presented (state HOLD)
//   out_ready : downstream takes the presented window
//   sum_out   : signed saturated sum of the window
//   cnt_out   : number of results in the window
//   sat_out   : the window clamped at least once
module alu_result_acc #(
    parameter int WIN   = 16,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       c_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum_out,
    output logic [4:0]       cnt_out,
    output logic             sat_out
);
    typedef enum logic {ACCUM, HOLD} state_t;
    localparam logic [ACC_W-1:0] acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] acc_min = {1'b1, {(ACC_W-1){1'b0}}};
    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [4:0]       cnt;
    logic             sat;
    logic             accept;
    logic             ovf;
    logic             close;
    logic [ACC_W:0]   sum_raw;
    logic [ACC_W-1:0] sum_sat;
    logic [4:0]       cnt_inc;
    assign in_ready  = state == ACCUM;
    assign out_valid = state == HOLD;
    assign accept    = in_valid && in_ready;
    // One guard bit: the top two bits disagree exactly when the add left the ACC_W range
    assign sum_raw   = {acc[ACC_W-1], acc} + {{(ACC_W-4){c_in[4]}}, c_in};
    assign ovf       = sum_raw[ACC_W] ^ sum_raw[ACC_W-1];
    assign sum_sat   = ovf ? (sum_raw[ACC_W] ? acc_min : acc_max) : sum_raw[ACC_W-1:0];
    assign cnt_inc   = cnt + 5'd1;
    // A flush arriving with the first sample still closes a non-empty window
    assign close     = (accept && cnt_inc == 5'(WIN)) || (flush && in_ready && (cnt != '0 || accept));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else if (state == ACCUM) begin
            if (accept) begin
                acc <= sum_sat;
                cnt <= cnt_inc;
                sat <= sat | ovf;
            end
            if (close)
                state <= HOLD;
        end else if (out_ready) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end
    end
    assign sum_out = acc;
    assign cnt_out = cnt;
    assign sat_out = sat;
endmodule

// File: tb/tb_alu_result_acc.sv
// tb_alu_result_acc: directed and randomized checks of alu_result_acc
module tb_alu_result_acc;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] c_in = '0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum_out;
    logic [4:0] cnt_out;
    logic       sat_out;
    int         total = 0;
    int         passed = 0;

    alu_result_acc #(.WIN(16), .ACC_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .c_in(c_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .sum_out(sum_out), .cnt_out(cnt_out), .sat_out(sat_out)
    );

    always #5 clk = ~clk;

    a_ready: assert property (@(posedge clk) disable iff (!reset) in_ready == !out_valid);
    a_stable: assert property (@(posedge clk) disable iff (!reset)
        out_valid && !out_ready |=> $stable(sum_out));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n, input int v);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            c_in = 5'(v);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_win(input string name, input int s, input int c, input bit st);
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum_out !== 8'(s) || cnt_out !== 5'(c) || sat_out !== st)
            $display("FAIL %s: got ov=%b ir=%b sum=%0d cnt=%0d sat=%b, want ov=1 ir=0 sum=%0d cnt=%0d sat=%b",
                     name, out_valid, in_ready, $signed(sum_out), cnt_out, sat_out, s, c, st);
        else
            passed++;
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || cnt_out !== 5'd0 || sum_out !== 8'd0 || sat_out !== 1'b0)
            $display("FAIL %s: got ir=%b ov=%b sum=%0d cnt=%0d sat=%b, want ir=1 ov=0 sum=0 cnt=0 sat=0",
                     name, in_ready, out_valid, $signed(sum_out), cnt_out, sat_out);
        else
            passed++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum_out !== 8'd0 || cnt_out !== 5'd0 || sat_out !== 1'b0)
            $display("FAIL reset: got ir=%b ov=%b sum=%0d cnt=%0d sat=%b, want ir=1 ov=0 sum=0 cnt=0 sat=0",
                     in_ready, out_valid, sum_out, cnt_out, sat_out);
        else
            passed++;
        reset = 1'b1;
        feed(1, 6);
        total++;
        if (sum_out !== 8'd6 || cnt_out !== 5'd1)
            $display("FAIL first_accept: got sum=%0d cnt=%0d, want sum=6 cnt=1", sum_out, cnt_out);
        else
            passed++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_win("single_flush", 6, 1, 1'b0);
        handshake("single_hs");
    endtask

    task automatic test_full_window();
        feed(15, 7);
        total++;
        if (out_valid !== 1'b0 || sum_out !== 8'd105 || cnt_out !== 5'd15)
            $display("FAIL running_15: got ov=%b sum=%0d cnt=%0d, want ov=0 sum=105 cnt=15", out_valid, sum_out, cnt_out);
        else
            passed++;
        feed(1, 7);
        check_win("full_7", 112, 16, 1'b0);
        step();
        check_win("full_7_held", 112, 16, 1'b0);
        handshake("full_hs");
    endtask

    task automatic test_saturation();
        feed(16, 15);
        check_win("sat_pos", 127, 16, 1'b1);
        handshake("sat_pos_hs");
        feed(16, -16);
        check_win("sat_neg", -128, 16, 1'b1);
        handshake("sat_neg_hs");
        feed(9, 15);
        feed(1, -16);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_win("sat_then_dec", 111, 10, 1'b1);
        handshake("sat_dec_hs");
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || cnt_out !== 5'd0)
            $display("FAIL flush_empty: got ov=%b ir=%b cnt=%0d, want ov=0 ir=1 cnt=0", out_valid, in_ready, cnt_out);
        else
            passed++;
        feed(1, 3);
        feed(1, -5);
        flush = 1'b1;
        feed(1, 4);
        flush = 1'b0;
        check_win("flush_with_accept", 2, 3, 1'b0);
        handshake("flush_hs");
        flush = 1'b1;
        feed(1, -9);
        flush = 1'b0;
        check_win("flush_first_sample", -9, 1, 1'b0);
        handshake("flush_first_hs");
    endtask

    task automatic test_backpressure();
        feed(16, 1);
        check_win("bp_close", 16, 16, 1'b0);
        in_valid = 1'b1;
        c_in = 5'd5;
        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_win("bp_hold", 16, 16, 1'b0);
        end
        flush = 1'b0;
        handshake("bp_hs");
        in_valid = 1'b0;
        step();
        total++;
        if (cnt_out !== 5'd0 || in_ready !== 1'b1)
            $display("FAIL bp_idle: got cnt=%0d ir=%b, want cnt=0 ir=1", cnt_out, in_ready);
        else
            passed++;
        out_ready = 1'b1;
        feed(16, 2);
        check_win("bp_ready_high", 32, 16, 1'b0);
        handshake("bp_hs2");
        feed(1, -3);
        total++;
        if (sum_out !== 8'hfd || cnt_out !== 5'd1)
            $display("FAIL b2b_accept: got sum=%0d cnt=%0d, want sum=-3 cnt=1", $signed(sum_out), cnt_out);
        else
            passed++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        handshake("b2b_hs");
    endtask

    task automatic test_reset_mid();
        feed(5, 2);
        #2 reset = 1'b0;
        #1;
        total++;
        if (sum_out !== 8'd0 || cnt_out !== 5'd0 || sat_out !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_mid: got sum=%0d cnt=%0d sat=%b ov=%b ir=%b, want all 0 and ir=1",
                     sum_out, cnt_out, sat_out, out_valid, in_ready);
        else
            passed++;
        step();
        reset = 1'b1;
        feed(16, 1);
        check_win("after_reset", 16, 16, 1'b0);
        #2 reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || cnt_out !== 5'd0)
            $display("FAIL reset_hold: got ov=%b cnt=%0d, want ov=0 cnt=0", out_valid, cnt_out);
        else
            passed++;
    endtask

    task automatic test_soak();
        bit m_hold = 1'b0;
        int m_acc = 0;
        int m_cnt = 0;
        bit m_sat = 1'b0;
        int v;
        int errs = 0;
        for (int i = 0; i < 2500; i++) begin
            v = $urandom_range(31) - 16;
            c_in = 5'(v);
            in_valid = $urandom_range(3) != 0;
            flush = $urandom_range(9) == 0;
            out_ready = $urandom_range(2) == 0;
            if (!m_hold) begin
                if (in_valid) begin
                    m_acc = m_acc + v;
                    if (m_acc > 127) begin m_acc = 127; m_sat = 1'b1; end
                    if (m_acc < -128) begin m_acc = -128; m_sat = 1'b1; end
                    m_cnt++;
                end
                if ((in_valid && m_cnt == 16) || (flush && m_cnt > 0))
                    m_hold = 1'b1;
            end else if (out_ready) begin
                m_hold = 1'b0;
                m_acc = 0;
                m_cnt = 0;
                m_sat = 1'b0;
            end
            step();
            total++;
            if (out_valid !== m_hold || in_ready !== !m_hold || sum_out !== 8'(m_acc)
                || cnt_out !== 5'(m_cnt) || sat_out !== m_sat) begin
                if (errs < 10)
                    $display("FAIL soak cycle %0d: got ov=%b sum=%0d cnt=%0d sat=%b, want ov=%b sum=%0d cnt=%0d sat=%b",
                             i, out_valid, $signed(sum_out), cnt_out, sat_out, m_hold, m_acc, m_cnt, m_sat);
                errs++;
            end else
                passed++;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_saturation();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_soak();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
